// File: rtl/tt_sequencer.sv
// Truth-table driver/checker for 2**N-input-combination gates: steps vec, samples s_in after
// SETTLE cycles, counts mismatches against TRUTH. Optional capture build: define TT_CAPTURE_EN.
module tt_sequencer #(
  parameter int              N      = 2,
  parameter int              SETTLE = 1,
  parameter logic [2**N-1:0] TRUTH  = 4'b1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [N-1:0]      vec,
  input  logic              s_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N:0]        mism,
  output logic [2**N-1:0]   obs_tt
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(SETTLE - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [N-1:0]  VEC_LAST  = {N{1'b1}};
  localparam logic [N-1:0]  VEC_ONE   = N'(1);
  localparam logic [N:0]    MISM_ONE  = (N + 1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [N-1:0]    vec_r;
  logic [CW-1:0]   cnt_r;
  logic [N:0]      mism_r;
  logic            pass_r;
  logic            busy_r;
  logic            done_r;
  logic            busy_s;
  logic            done_s;
  logic            miss_s;

  function automatic logic tt_expect(input logic [N-1:0] v);
    return TRUTH[v];
  endfunction

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_SETTLE;
        else       state_s = ST_IDLE;
      end
      ST_SETTLE: begin
        if (cnt_r == CNT_LAST) state_s = ST_SAMPLE;
        else                   state_s = ST_SETTLE;
      end
      ST_SAMPLE: begin
        if (vec_r == VEC_LAST) state_s = ST_DONE;
        else                   state_s = ST_SETTLE;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM output decode, evaluated on the next state so busy/done can be registered
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_s)
      ST_SETTLE: busy_s = 1'b1;
      ST_SAMPLE: busy_s = 1'b1;
      ST_DONE:   done_s = 1'b1;
      ST_IDLE:   busy_s = 1'b0;
      default:   busy_s = 1'b0;
    endcase
  end

  // Sample-time comparison against the expected truth table
  always_comb begin
    if (s_in != tt_expect(vec_r)) miss_s = 1'b1;
    else                          miss_s = 1'b0;
  end

  // Registered busy/done flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_s;
      done_r <= done_s;
    end
  end

  // Vector stepping, settle counting, mismatch accounting and verdict
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_r  <= {N{1'b0}};
      cnt_r  <= {CW{1'b0}};
      mism_r <= {(N + 1){1'b0}};
      pass_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            vec_r  <= {N{1'b0}};
            cnt_r  <= {CW{1'b0}};
            mism_r <= {(N + 1){1'b0}};
            pass_r <= 1'b0;
          end
        end
        ST_SETTLE: begin
          cnt_r <= cnt_r + CNT_ONE;
        end
        ST_SAMPLE: begin
          if (miss_s) mism_r <= mism_r + MISM_ONE;
          if (vec_r != VEC_LAST) begin
            vec_r <= vec_r + VEC_ONE;
            cnt_r <= {CW{1'b0}};
          end
        end
        ST_DONE: begin
          pass_r <= (mism_r == {(N + 1){1'b0}});
          vec_r  <= {N{1'b0}};
        end
        default: begin
          vec_r <= {N{1'b0}};
        end
      endcase
    end
  end

`ifdef TT_CAPTURE_EN
  logic [2**N-1:0] obs_r;

  // Observed truth table capture, one bit per sampled vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      obs_r <= {(2**N){1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) obs_r <= {(2**N){1'b0}};
        end
        ST_SAMPLE: obs_r[vec_r] <= s_in;
        default:   obs_r <= obs_r;
      endcase
    end
  end

  assign obs_tt = obs_r;
`else
  assign obs_tt = {(2**N){1'b0}};
`endif

  assign vec  = vec_r;
  assign busy = busy_r;
  assign done = done_r;
  assign pass = pass_r;
  assign mism = mism_r;

endmodule

// File: tb/tb_tt_sequencer.sv
// Bench for tt_sequencer: a cycle-count model of each run checks every cycle, and directed
// runs pin latency, verdicts and the reset/ignored-start corner cases with literal values.
module tb_tt_sequencer;

  localparam int NV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_w [2];
  logic       s_in_w  [2];
  logic [1:0] vec_w   [2];
  logic       busy_w  [2];
  logic       done_w  [2];
  logic       pass_w  [2];
  logic [2:0] mism_w  [2];
  logic [3:0] obs_w   [2];
  int         mode_r  [2];

  int n_checks = 0;
  int n_errs   = 0;

  // model state per instance
  bit       act_m  [2];
  int       e_m    [2];
  int       mism_m [2];
  bit       pass_m [2];
  logic [3:0] obs_m [2];
  int       per_m  [2];

  always #5 clk = ~clk;

  // mode 0: AND, mode 1: stuck at 1, otherwise NAND
  function automatic logic gate_f(input int mode, input logic [1:0] v);
    case (mode)
      0:       return v[1] & v[0];
      1:       return 1'b1;
      default: return ~(v[1] & v[0]);
    endcase
  endfunction

  assign s_in_w[0] = gate_f(mode_r[0], vec_w[0]);
  assign s_in_w[1] = gate_f(mode_r[1], vec_w[1]);

  tt_sequencer #(.N(2), .SETTLE(1), .TRUTH(4'b1000)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_w[0]), .vec(vec_w[0]), .s_in(s_in_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .mism(mism_w[0]), .obs_tt(obs_w[0])
  );

  tt_sequencer #(.N(2), .SETTLE(3), .TRUTH(4'b1000)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_w[1]), .vec(vec_w[1]), .s_in(s_in_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .mism(mism_w[1]), .obs_tt(obs_w[1])
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: a run is a count of elapsed cycles; each vector lasts SETTLE+1 cycles, sampled in its last
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int ev;
      int eb;
      int ed;
      int v;
      logic s;
      if (!rst_n) begin
        act_m[i]  = 1'b0;
        mism_m[i] = 0;
        pass_m[i] = 1'b0;
        obs_m[i]  = 4'b0000;
      end
      if (act_m[i] && e_m[i] <= NV * per_m[i]) begin
        ev = (e_m[i] - 1) / per_m[i]; eb = 1; ed = 0;
      end else if (act_m[i]) begin
        ev = NV - 1; eb = 0; ed = 1;
      end else begin
        ev = 0; eb = 0; ed = 0;
      end
      chk($sformatf("vec[%0d]", i),  int'(vec_w[i]),  ev);
      chk($sformatf("busy[%0d]", i), int'(busy_w[i]), eb);
      chk($sformatf("done[%0d]", i), int'(done_w[i]), ed);
      chk($sformatf("mism[%0d]", i), int'(mism_w[i]), mism_m[i]);
      chk($sformatf("pass[%0d]", i), int'(pass_w[i]), int'(pass_m[i]));
`ifdef TT_CAPTURE_EN
      chk($sformatf("obs[%0d]", i),  int'(obs_w[i]),  int'(obs_m[i]));
`else
      chk($sformatf("obs[%0d]", i),  int'(obs_w[i]),  0);
`endif
      if (!rst_n) begin
        act_m[i] = 1'b0;
      end else if (act_m[i] && e_m[i] <= NV * per_m[i]) begin
        if (e_m[i] % per_m[i] == 0) begin
          v = (e_m[i] - 1) / per_m[i];
          s = gate_f(mode_r[i], 2'(v));
          if (s != (v == 3)) mism_m[i]++;
          obs_m[i][v] = s;
        end
        e_m[i]++;
      end else if (act_m[i]) begin
        pass_m[i] = (mism_m[i] == 0);
        act_m[i]  = 1'b0;
      end else if (start_w[i]) begin
        act_m[i]  = 1'b1;
        e_m[i]    = 1;
        mism_m[i] = 0;
        pass_m[i] = 1'b0;
        obs_m[i]  = 4'b0000;
      end
    end
  end

  // One run: start pulse, optional extra start at cycle poke, optional reset at cycle rst_at
  task automatic run_seq(input int inst, input int mode, input int poke, input int rst_at,
                         input int exp_done, input int window);
    int first_done;
    int n_done;
    @(posedge clk); #1;
    mode_r[inst]  = mode;
    start_w[inst] = 1'b1;
    first_done = 0;
    n_done = 0;
    for (int cyc = 1; cyc <= window; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1 || cyc == poke + 1) start_w[inst] = 1'b0;
      if (cyc == poke) start_w[inst] = 1'b1;
      if (cyc == rst_at + 1 && rst_at != 0) rst_n = 1'b1;
      if (cyc == rst_at) begin
        chk("pre_rst_vec", int'(vec_w[inst]), 2);
        rst_n = 1'b0;
        #1;
        chk("rst_vec",  int'(vec_w[inst]),  0);
        chk("rst_busy", int'(busy_w[inst]), 0);
        chk("rst_mism", int'(mism_w[inst]), 0);
        chk("rst_obs",  int'(obs_w[inst]),  0);
      end
      if (done_w[inst]) begin
        n_done++;
        if (first_done == 0) first_done = cyc;
      end
    end
    chk("done_cycle", first_done, exp_done);
    chk("done_count", n_done, (exp_done == 0) ? 0 : 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    per_m[0] = 2;
    per_m[1] = 4;
    for (int i = 0; i < 2; i++) begin
      start_w[i] = 1'b0;
      mode_r[i]  = 0;
      act_m[i]   = 1'b0;
      e_m[i]     = 0;
      mism_m[i]  = 0;
      pass_m[i]  = 1'b0;
      obs_m[i]   = 4'b0000;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy_w[0]), 0);
    chk("reset_done", int'(done_w[0]), 0);
    chk("reset_vec",  int'(vec_w[0]),  0);
    rst_n = 1'b1;

    // correct AND gate
    run_seq(0, 0, 0, 0, 9, 14);
    chk("and_mism", int'(mism_w[0]), 0);
    chk("and_pass", int'(pass_w[0]), 1);
`ifdef TT_CAPTURE_EN
    chk("and_obs", int'(obs_w[0]), 8);
`endif

    // stuck-at-1 output
    run_seq(0, 1, 0, 0, 9, 14);
    chk("stuck_mism", int'(mism_w[0]), 3);
    chk("stuck_pass", int'(pass_w[0]), 0);
`ifdef TT_CAPTURE_EN
    chk("stuck_obs", int'(obs_w[0]), 15);
`endif

    // inverted gate: every vector mismatches
    run_seq(0, 2, 0, 0, 9, 14);
    chk("inv_mism", int'(mism_w[0]), 4);
    chk("inv_pass", int'(pass_w[0]), 0);
`ifdef TT_CAPTURE_EN
    chk("inv_obs", int'(obs_w[0]), 7);
`endif

    // extra start while busy at vec=1 is ignored
    run_seq(0, 0, 3, 0, 9, 16);
    chk("poke_pass", int'(pass_w[0]), 1);

    // reset while vec=2: run abandoned, no done
    run_seq(0, 0, 0, 5, 0, 14);
    chk("rstrun_pass", int'(pass_w[0]), 0);
    run_seq(0, 0, 0, 0, 9, 14);
    chk("after_rst_pass", int'(pass_w[0]), 1);

    // SETTLE=3 instance
    run_seq(1, 0, 0, 0, 17, 22);
    chk("s3_mism", int'(mism_w[1]), 0);
    chk("s3_pass", int'(pass_w[1]), 1);

    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
